// File: rtl/apb_completer_regfile_if.sv
// APB3 link between master and completer regfile.
// Only the transfer and response signals are grouped here; clock and reset stay scalar ports.
interface apb_completer_regfile_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_completer_regfile.sv
// APB3 completer backed by a DEPTH x DATA_W register file, with programmable
// wait states, out-of-range error response and a sticky protocol-violation flag.
module apb_completer_regfile #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  apb_completer_regfile_if.slave       bus,
  output logic                         proto_err
);
  localparam int               CNT_W     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [ADDR_W:0]  DEPTH_V   = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WAIT_STATES);
  localparam logic             ZERO_WAIT = (WAIT_STATES == 0);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic              write;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t                        state;
  logic [CNT_W-1:0]              cnt;
  req_t                          req;
  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  logic [DATA_W-1:0]             prdata_q;
  logic                          pready_q;
  logic                          pslverr_q;

  logic                          setup;
  logic                          in_err;
  logic [DATA_W-1:0]             rd_mux;

  assign setup       = bus.psel & ~bus.penable;
  assign in_err      = {1'b0, bus.paddr} >= DEPTH_V;
  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

  // Out-of-range addresses match no entry and therefore read as 0.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.paddr == ADDR_W'(i)) rd_mux = mem[i];
  end

  // pready/pslverr are registered one edge ahead, so they depend on state only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req       <= '0;
      mem       <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      proto_err <= 1'b0;
    end else if (setup) begin
      // A setup seen while already in ACCESS is a restart: flag it, then capture anew.
      state     <= ACCESS;
      cnt       <= CNT_LOAD;
      req       <= '{write: bus.pwrite, err: in_err, addr: bus.paddr, wdata: bus.pwdata};
      if (!bus.pwrite) prdata_q <= rd_mux;
      pready_q  <= ZERO_WAIT;
      pslverr_q <= ZERO_WAIT & in_err;
      if (state == ACCESS) proto_err <= 1'b1;
    end else if (state == IDLE) begin
      if (bus.psel) proto_err <= 1'b1;
    end else if (!bus.psel) begin
      state     <= IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      proto_err <= 1'b1;
    end else if (cnt != '0) begin
      cnt       <= cnt - 1'b1;
      pready_q  <= (cnt == CNT_W'(1));
      pslverr_q <= (cnt == CNT_W'(1)) & req.err;
    end else begin
      if (req.write && !req.err)
        for (int i = 0; i < DEPTH; i++)
          if (req.addr == ADDR_W'(i)) mem[i] <= req.wdata;
      state     <= IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_apb_completer_regfile.sv
// Randomized bench for apb_completer_regfile: a zero-wait and a one-wait instance
// driven independently and compared against a plain array model.
module tb_apb_completer_regfile;
  localparam int DEPTH = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       psel[2], penable[2], pwrite[2];
  logic [3:0] paddr[2];
  logic [7:0] pwdata[2], prdata[2];
  logic       pready[2], pslverr[2], proto_err[2];

  int checks   = 0;
  int failures = 0;

  logic [7:0] mmem[2][16];
  logic [7:0] mlast[2];
  bit         mproto[2];

  apb_completer_regfile_if #(.ADDR_W(4), .DATA_W(8)) b0 ();
  apb_completer_regfile_if #(.ADDR_W(4), .DATA_W(8)) b1 ();

  assign b0.psel = psel[0];    assign b1.psel = psel[1];
  assign b0.penable = penable[0]; assign b1.penable = penable[1];
  assign b0.pwrite = pwrite[0];  assign b1.pwrite = pwrite[1];
  assign b0.paddr = paddr[0];    assign b1.paddr = paddr[1];
  assign b0.pwdata = pwdata[0];  assign b1.pwdata = pwdata[1];
  assign prdata[0] = b0.prdata;  assign prdata[1] = b1.prdata;
  assign pready[0] = b0.pready;  assign pready[1] = b1.pready;
  assign pslverr[0] = b0.pslverr; assign pslverr[1] = b1.pslverr;

  apb_completer_regfile #(.ADDR_W(4), .DATA_W(8), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .bus(b0), .proto_err(proto_err[0]));
  apb_completer_regfile #(.ADDR_W(4), .DATA_W(8), .DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .bus(b1), .proto_err(proto_err[1]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 16; a++) mmem[d][a] = 8'h00;
      mlast[d]  = 8'h00;
      mproto[d] = 1'b0;
    end
  endtask

  task automatic idle(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  // Starts just after a rising edge; returns just after the completion edge.
  task automatic xfer(input int d, input bit wr, input logic [3:0] a, input logic [7:0] wd);
    int         w;
    bit         done;
    bit         exp_err;
    logic [7:0] exp_rd;
    exp_err = (a >= DEPTH);
    exp_rd  = exp_err ? 8'h00 : mmem[d][a];
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(negedge clk);
    chk("setup_rdy", pready[d], 0);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    w = 0; done = 0;
    while (!done && w <= 8) begin
      paddr[d]  = 4'($urandom);
      pwdata[d] = 8'($urandom);
      @(negedge clk);
      if (!wr) chk("rd_data", prdata[d], exp_rd);
      if (pready[d]) begin
        chk("waits", w, d);
        chk("slverr", pslverr[d], exp_err);
        chk("proto", proto_err[d], mproto[d]);
        if (wr) chk("rd_hold", prdata[d], mlast[d]);
        done = 1;
      end else begin
        chk("wait_err", pslverr[d], 0);
        w++;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("timeout", 0, 1);
    if (wr && !exp_err) mmem[d][a] = wd;
    if (!wr) mlast[d] = exp_rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] addrs[10];
    reset_model();
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = 0; pwdata[d] = 0;
    end

    // Reset with random bus activity.
    repeat (5) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        psel[d] = 1'($urandom); penable[d] = 1'($urandom); pwrite[d] = 1'($urandom);
        paddr[d] = 4'($urandom); pwdata[d] = 8'($urandom);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rst_prdata", prdata[d], 0);
        chk("rst_pready", pready[d], 0);
        chk("rst_pslverr", pslverr[d], 0);
        chk("rst_proto", proto_err[d], 0);
      end
    end
    psel[0] = 0; psel[1] = 0; penable[0] = 0; penable[1] = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < DEPTH; a++) xfer(d, 0, 4'(a), 8'h00);
      idle(d);
    end

    // Write then read with one wait state.
    xfer(1, 1, 4'd3, 8'hA5);
    xfer(1, 0, 4'd3, 8'h00);
    chk("wr_rd_a5", prdata[1], 8'hA5);
    idle(1);

    // Out-of-range write and read.
    xfer(1, 1, 4'd13, 8'h5A);
    xfer(1, 0, 4'd13, 8'h00);
    chk("oor_rd", prdata[1], 8'h00);
    for (int a = 0; a < DEPTH; a++) xfer(1, 0, 4'(a), 8'h00);
    idle(1);

    // Back-to-back zero-wait traffic.
    for (int i = 0; i < 10; i++) begin
      addrs[i] = 4'($urandom_range(0, DEPTH - 1));
      xfer(0, 1, addrs[i], 8'($urandom));
    end
    for (int i = 0; i < 10; i++) xfer(0, 0, addrs[i], 8'h00);
    idle(0);

    // Random mixed traffic including out-of-range and idle gaps.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 30; i++) begin
        xfer(d, 1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom));
        if ($urandom_range(0, 2) == 0) idle(d);
      end
      idle(d);
    end

    // Access phase without setup: flag, no ready, no write.
    psel[1] = 1; penable[1] = 1; pwrite[1] = 1; paddr[1] = 4'd5; pwdata[1] = 8'hEE;
    @(negedge clk);
    chk("noset_rdy0", pready[1], 0);
    @(posedge clk); #1;
    mproto[1] = 1'b1;
    @(negedge clk);
    chk("noset_proto", proto_err[1], 1);
    chk("noset_rdy1", pready[1], 0);
    @(posedge clk); #1;
    idle(1);
    xfer(1, 0, 4'd5, 8'h00);

    // Abort a write by dropping psel in the wait state.
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 4'd2; pwdata[1] = 8'h11;
    @(posedge clk); #1;
    psel[1] = 0;
    @(negedge clk);
    chk("abort_rdy", pready[1], 0);
    @(posedge clk); #1;
    xfer(1, 0, 4'd2, 8'h00);
    xfer(1, 0, 4'd7, 8'h00);
    idle(1);
    chk("proto_sticky", proto_err[1], 1);

    // Reset while both instances are mid-write to address 4.
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1; penable[d] = 0; pwrite[d] = 1; paddr[d] = 4'd4; pwdata[d] = 8'hFF;
    end
    @(posedge clk); #1;
    penable[0] = 1; penable[1] = 1;
    @(negedge clk);
    chk("mid_rdy_ws0", pready[0], 1);
    chk("mid_rdy_ws1", pready[1], 0);
    #1 rst = 1'b1;
    #1;
    chk("mid_drop_ws0", pready[0], 0);
    chk("mid_drop_ws1", pready[1], 0);
    chk("mid_proto_clr", proto_err[1], 0);
    reset_model();
    psel[0] = 0; psel[1] = 0; penable[0] = 0; penable[1] = 0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    xfer(0, 0, 4'd4, 8'h00);
    chk("post_rst_ws0", prdata[0], 8'h00);
    idle(0);
    xfer(1, 0, 4'd4, 8'h00);
    chk("post_rst_ws1", prdata[1], 8'h00);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
